// File: rtl/wb_ser_tx.sv
// wb_ser_tx - Wishbone classic register slave feeding a framed serial transmitter.
//
// A small frame FIFO holds 10-bit words written over Wishbone. Each word is sent
// as one frame: SYNC (ena_o=1, data_o=0), 10 data bits LSB first, an optional
// even-parity bit, then a GAP period. Every phase lasts one bit period of DIV+1
// clocks. DIV comes from CTRL and is latched only when a frame starts.
//
// Optional feature macro: WB_SER_TX_PARITY_EN (adds the PAR state after DATA).
//
// Ports:
//   CLK_I   clock; all state changes on its rising edge
//   RST_I   asynchronous active-high reset
//   CYC_I, STB_I, WE_I, ADR_I[31:0], DAT_I[31:0]  Wishbone request
//   DAT_O[31:0], ACK_O                            Wishbone response
//   ena_o   frame marker (high during SYNC)
//   data_o  serial data, LSB first
//
// Register map (ADR_I[3:2]):
//   0x0 DATA   W    push DAT_I[9:0]
//   0x4 STATUS R/W1C [4:0] count, [5] full, [6] empty, [7] busy, [8] overflow
//   0x8 CTRL   R/W  [7:0] DIV
//   0xC reserved    reads 0, writes ignored
module wb_ser_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RST    = 3
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ena_o,
  output logic        data_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef WB_SER_TX_PARITY_EN
  localparam logic [2:0] S_PAR  = 3'd3;
`endif
  localparam logic [2:0] S_GAP  = 3'd4;

  logic          r_ack;
  logic [31:0]   r_dat;
  logic [7:0]    r_div;
  logic          r_ovf;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_state;
  logic [7:0]    r_tick;
  logic [7:0]    r_div_act;
  logic [9:0]    r_shift;
  logic [3:0]    r_bit_idx;
`ifdef WB_SER_TX_PARITY_EN
  logic          r_par;
`endif

  logic        w_req, w_wr, w_rd;
  logic [1:0]  w_adr;
  logic        w_full, w_empty, w_busy;
  logic        w_bit_end, w_pop, w_push_req, w_push, w_ovf_set, w_ovf_clr;
  logic [31:0] w_status, w_rdata;
  logic        w_unused;

  // Only one request per ACK: the cycle carrying ACK_O never starts a new access.
  assign w_req      = CYC_I & STB_I & ~r_ack;
  assign w_wr       = w_req & WE_I;
  assign w_rd       = w_req & ~WE_I;
  assign w_adr      = ADR_I[3:2];
  assign w_unused   = &{1'b0, ADR_I[31:4], ADR_I[1:0], DAT_I[31:10]};

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_bit_end  = (r_tick == r_div_act);

  // A frame starts (and pops) straight from IDLE, or back-to-back at the end of GAP.
  assign w_pop      = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_GAP) & w_bit_end));
  assign w_push_req = w_wr & (w_adr == 2'd0);
  // When full, a same-cycle pop frees the slot, so the push still lands.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_ovf_clr  = w_wr & (w_adr == 2'd1) & DAT_I[8];

  assign w_status   = {23'd0, r_ovf, w_busy, w_empty, w_full, 5'(r_count)};

  always_comb begin
    w_rdata = 32'd0;
    case (w_adr)
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = {24'd0, r_div};
      default: w_rdata = 32'd0;
    endcase
  end

  assign ACK_O  = r_ack;
  assign DAT_O  = r_dat;
  assign ena_o  = (r_state == S_SYNC);
`ifdef WB_SER_TX_PARITY_EN
  assign data_o = ((r_state == S_DATA) & r_shift[0]) | ((r_state == S_PAR) & r_par);
`else
  assign data_o = (r_state == S_DATA) & r_shift[0];
`endif

  // Bus side: ack, read data, CTRL, overflow flag.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
      r_div <= 8'(DIV_RST);
      r_ovf <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;
      if (w_wr && (w_adr == 2'd2)) r_div <= DAT_I[7:0];
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // FIFO storage has no reset so it can map to RAM; only pointers are reset.
  always_ff @(posedge CLK_I) begin
    if (w_push) r_mem[r_wptr] <= DAT_I[9:0];
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Transmit FSM; r_tick counts clocks inside the current bit period.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state   <= S_IDLE;
      r_tick    <= 8'd0;
      r_div_act <= 8'(DIV_RST);
      r_shift   <= 10'd0;
      r_bit_idx <= 4'd0;
`ifdef WB_SER_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else if (w_pop) begin
      r_state   <= S_SYNC;
      r_tick    <= 8'd0;
      r_div_act <= r_div;
      r_shift   <= r_mem[r_rptr];
      r_bit_idx <= 4'd0;
`ifdef WB_SER_TX_PARITY_EN
      r_par     <= ^r_mem[r_rptr];
`endif
    end else if (r_state != S_IDLE) begin
      if (!w_bit_end) begin
        r_tick <= r_tick + 8'd1;
      end else begin
        r_tick <= 8'd0;
        case (r_state)
          S_SYNC: r_state <= S_DATA;
          S_DATA: begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == 4'd9) begin
              r_bit_idx <= 4'd0;
`ifdef WB_SER_TX_PARITY_EN
              r_state   <= S_PAR;
`else
              r_state   <= S_GAP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end
`ifdef WB_SER_TX_PARITY_EN
          S_PAR:  r_state <= S_GAP;
`endif
          // End of GAP with an empty FIFO (a non-empty one is taken by w_pop).
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_ser_tx.sv
module tb_wb_ser_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = 32'd0, dat_i = 32'd0;
  logic [31:0] dat_o;
  logic        ack, ena, sdata;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  logic ena_prev = 1'b0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  wb_ser_tx #(.FIFO_DEPTH(4), .DIV_RST(3)) dut (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .DAT_I(dat_i), .DAT_O(dat_o), .ACK_O(ack),
    .ena_o(ena), .data_o(sdata)
  );

  // Count frames by rising edges of the frame marker.
  always @(negedge clk) begin
    if (ena === 1'b1 && ena_prev !== 1'b1) frames <= frames + 1;
    ena_prev <= ena;
  end

  typedef struct {
    string       name;
    logic        c, s, w;
    logic [31:0] a, d;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One Wishbone access: request sampled on the first rising edge, ACK checked
  // after it, then one idle edge confirming ACK/DAT_O fall back to zero.
  task automatic wb(input logic c, input logic s, input logic w, input logic [31:0] a,
                    input logic [31:0] d, input logic exp_ack, output logic [31:0] rd);
    @(negedge clk);
    cyc = c; stb = s; we = w; adr = a; dat_i = d;
    @(posedge clk); #1;
    chk("ack", 32'(ack), 32'(exp_ack));
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_pulse", 32'(ack), 32'd0);
    chk("dat_idle", dat_o, 32'd0);
    if (verbose)
      $display("wb cyc=%0b stb=%0b we=%0b adr=0x%08h dat=0x%08h ack_exp=%0b rd=0x%08h",
               c, s, w, a, d, exp_ack, rd);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    wb(1'b1, 1'b1, 1'b1, a, d, 1'b1, rd);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b1, rd);
    chk(name, rd, exp);
  endtask

  // Follows one frame on the serial pins; exp_wait >= 0 pins the number of
  // falling edges until the SYNC marker is first seen.
  task automatic check_frame(input logic [9:0] w, input int div, input int exp_wait,
                             input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ena !== 1'b1 && n < 20000);
    chk($sformatf("%s_sync_seen", tag), 32'(ena), 32'd1);
    if (ena !== 1'b1) return;
    if (exp_wait >= 0) chk($sformatf("%s_latency", tag), 32'(n), 32'(exp_wait));
    chk($sformatf("%s_sync", tag), 32'({ena, sdata}), 32'd2);
    repeat (div) begin
      @(negedge clk);
      chk($sformatf("%s_sync", tag), 32'({ena, sdata}), 32'd2);
    end
    for (int b = 0; b < 10; b++) begin
      repeat (div + 1) begin
        @(negedge clk);
        chk($sformatf("%s_bit%0d", tag, b), 32'({ena, sdata}), 32'({1'b0, w[b]}));
      end
    end
`ifdef WB_SER_TX_PARITY_EN
    repeat (div + 1) begin
      @(negedge clk);
      chk($sformatf("%s_par", tag), 32'({ena, sdata}), 32'({1'b0, ^w}));
    end
`endif
    repeat (div + 1) begin
      @(negedge clk);
      chk($sformatf("%s_gap", tag), 32'({ena, sdata}), 32'd0);
    end
    $display("frame %s word=0x%03h div=%0d waited=%0d", tag, w, div, n);
  endtask

  initial begin
    logic [31:0] rd;
    int f0;
    int polls;

    vecs[0]  = '{"status_rst",  1, 1, 0, 32'h4,        32'h0,        1, 32'h40};
    vecs[1]  = '{"ctrl_rst",    1, 1, 0, 32'h8,        32'h0,        1, 32'h3};
    vecs[2]  = '{"ctrl_wr",     1, 1, 1, 32'h8,        32'h5A,       1, 32'h0};
    vecs[3]  = '{"ctrl_rd",     1, 1, 0, 32'h8,        32'h0,        1, 32'h5A};
    vecs[4]  = '{"no_cyc",      0, 1, 1, 32'h8,        32'hFF,       0, 32'h0};
    vecs[5]  = '{"no_stb",      1, 0, 1, 32'h8,        32'hEE,       0, 32'h0};
    vecs[6]  = '{"ctrl_kept",   1, 1, 0, 32'h8,        32'h0,        1, 32'h5A};
    vecs[7]  = '{"rsv_wr",      1, 1, 1, 32'hC,        32'hFFFFFFFF, 1, 32'h0};
    vecs[8]  = '{"rsv_rd",      1, 1, 0, 32'hC,        32'h0,        1, 32'h0};
    vecs[9]  = '{"data_rd",     1, 1, 0, 32'h0,        32'h0,        1, 32'h0};
    vecs[10] = '{"status_alias",1, 1, 0, 32'hFFFFFFF4, 32'h0,        1, 32'h40};
    vecs[11] = '{"ctrl_wr_hi",  1, 1, 1, 32'h8,        32'hFFFFFF03, 1, 32'h0};
    vecs[12] = '{"ctrl_rd3",    1, 1, 0, 32'h8,        32'h0,        1, 32'h3};
    vecs[13] = '{"status_w1c",  1, 1, 1, 32'h4,        32'h100,      1, 32'h0};
    vecs[14] = '{"status_idle", 1, 1, 0, 32'h4,        32'h0,        1, 32'h40};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_ena", 32'(ena), 32'd0);
    chk("rst_data", 32'(sdata), 32'd0);
    rst = 1'b0;

    // Register map vectors.
    for (int i = 0; i < 15; i++) begin
      wb(vecs[i].c, vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_ack, rd);
      chk(vecs[i].name, rd, vecs[i].exp_rd);
    end

    // Single frame, DIV=3: SYNC marker is seen on the first falling edge after the access.
    wr(32'h0, 32'h30201);
    check_frame(10'h201, 3, 1, "single");
    rd_chk("status_after_single", 32'h4, 32'h40);

    // Back-to-back frames separated only by one GAP; busy read all along.
    fork
      begin
        check_frame(10'h155, 3, -1, "b2b_a");
        check_frame(10'h2AA, 3, 1, "b2b_b");
      end
      begin
        wr(32'h0, 32'h155);
        wr(32'h0, 32'h2AA);
        for (int k = 0; k < 35; k++) begin
          wb(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, rd);
          chk("b2b_busy", 32'(rd[7]), 32'd1);
        end
      end
    join
    rd_chk("status_after_b2b", 32'h4, 32'h40);

    // CTRL change mid-frame: current frame keeps DIV=3, next uses DIV=1.
    fork
      begin
        check_frame(10'h0F0, 3, -1, "div_old");
        check_frame(10'h30F, 1, 1, "div_new");
      end
      begin
        wr(32'h0, 32'h0F0);
        wr(32'h0, 32'h30F);
        wr(32'h8, 32'h1);
        rd_chk("ctrl_mid", 32'h8, 32'h1);
      end
    join

`ifdef WB_SER_TX_PARITY_EN
    wr(32'h8, 32'h3);
    wr(32'h0, 32'h007);
    check_frame(10'h007, 3, 1, "par1");
    wr(32'h0, 32'h003);
    check_frame(10'h003, 3, 1, "par0");
`endif

    // Overflow: 6 writes at DIV=255 -> one popped, four stored, one dropped.
    wr(32'h8, 32'hFF);
    f0 = frames;
    for (int k = 0; k < 6; k++) wr(32'h0, 32'(k + 1));
    rd_chk("status_ovf", 32'h4, 32'h1A4);
    wr(32'h4, 32'h100);
    rd_chk("status_ovf_clr", 32'h4, 32'hA4);
    verbose = 1'b0;
    polls = 0;
    do begin
      wb(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, rd);
      polls++;
    end while (rd[7] === 1'b1 && polls < 12000);
    verbose = 1'b1;
    chk("ovf_drain_idle", 32'(rd[7]), 32'd0);
    chk("ovf_frames", 32'(frames - f0), 32'd5);
    $display("overflow drained after %0d status polls, frames=%0d", polls, frames - f0);
    rd_chk("status_after_ovf", 32'h4, 32'h40);

    // Reset during DATA bit 5 at DIV=2 (3 clocks per bit).
    wr(32'h8, 32'h2);
    wr(32'h0, 32'h3E0);
    polls = 0;
    do begin
      @(negedge clk);
      polls++;
    end while (ena !== 1'b1 && polls < 100);
    chk("rst_frame_sync", 32'(ena), 32'd1);
    repeat (2 + 5 * 3 + 1) @(negedge clk);
    chk("rst_pre_bit5", 32'({ena, sdata}), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_ena", 32'(ena), 32'd0);
    chk("rst_async_data", 32'(sdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    f0 = frames;
    rd_chk("status_after_rst", 32'h4, 32'h40);
    rd_chk("ctrl_after_rst", 32'h8, 32'h3);
    repeat (200) @(negedge clk);
    chk("no_frames_after_rst", 32'(frames - f0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
